// File: rtl/uart_status_reporter.sv
// uart_status_reporter
// Snapshots one channel's configuration and status through the mapper lookup,
// frames it as a checksummed byte packet and streams it into uart_tx over a
// start/busy handshake.
module uart_status_reporter #(
    parameter int _NUM_CHANNELS = 4,
    parameter int _PAT_WIDTH    = 32
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [7:0]            rd_req_ch,
    output logic [7:0]            rd_ch,
    input  logic [7:0]            rd_ctrl_sta,
    input  logic [7:0]            rd_duty_num,
    input  logic [15:0]           rd_pulse_dessert,
    input  logic [7:0]            rd_pulse_num,
    input  logic [_PAT_WIDTH-1:0] rd_pat,
    input  logic                  rd_busy,
    input  logic                  rd_valid,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  rep_busy,
    output logic                  rep_done,
    output logic                  req_drop
);

    localparam int          FRAME_MAX = 15;
    localparam logic [31:0] NUM_CH    = 32'(_NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_rd_ch;
    logic       r_tx_en;
    logic [7:0] r_tx_data;
    logic       r_rep_busy;
    logic       r_rep_done;
    logic       r_req_drop;
    logic       r_wait_first;
    logic [3:0] r_idx;
    logic [3:0] r_last;
    logic [7:0] r_buf [FRAME_MAX];

    logic       w_accept;
    logic       w_capture;
    logic       w_launch;
    logic       w_byte_done;
    logic       w_advance;
    logic       w_finish;
    logic       w_drop;

    logic       w_ch_ok;
    logic [7:0] w_status;
    logic [7:0] w_sum;
    logic [3:0] w_last;
    logic [7:0] w_frame [FRAME_MAX];

    assign rd_ch    = r_rd_ch;
    assign tx_en    = r_tx_en;
    assign tx_data  = r_tx_data;
    assign rep_busy = r_rep_busy;
    assign rep_done = r_rep_done;
    assign req_drop = r_req_drop;

    // State register
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; WAIT skips tx_busy on its first cycle so uart_tx has time to raise it
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (rd_req) w_next = S_SELECT;
            S_SELECT:  w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND;
            S_SEND:    if (!tx_busy) w_next = S_WAIT;
            S_WAIT: begin
                if (!r_wait_first && !tx_busy)
                    w_next = (r_idx == r_last) ? S_DONE : S_SEND;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Control strobes derived from the current state and handshake inputs
    always_comb begin
        w_accept    = (r_state == S_IDLE) && rd_req;
        w_capture   = (r_state == S_CAPTURE);
        w_launch    = (r_state == S_SEND) && !tx_busy;
        w_byte_done = (r_state == S_WAIT) && !r_wait_first && !tx_busy;
        w_advance   = w_byte_done && (r_idx != r_last);
        w_finish    = w_byte_done && (r_idx == r_last);
        // Anything outside IDLE is a frame in progress, including the DONE cycle
        w_drop      = rd_req && (r_state != S_IDLE);
    end

    // Frame image built from the live lookup; only latched in CAPTURE
    always_comb begin
        w_ch_ok  = ({24'd0, r_rd_ch} < NUM_CH);
        w_status = {6'd0, rd_valid, rd_busy};
        w_sum    = 8'h00;
        w_last   = 4'd0;
        for (int i = 0; i < FRAME_MAX; i++) w_frame[i] = 8'h00;
        w_frame[0] = 8'h55;
        w_frame[1] = 8'hAA;
        w_frame[3] = r_rd_ch;
        if (w_ch_ok) begin
            // Modulo-256 sum of everything after the sync bytes
            w_sum = 8'h81 + r_rd_ch + rd_ctrl_sta + rd_duty_num
                  + rd_pulse_dessert[15:8] + rd_pulse_dessert[7:0] + rd_pulse_num
                  + rd_pat[31:24] + rd_pat[23:16] + rd_pat[15:8] + rd_pat[7:0]
                  + w_status;
            w_frame[2]  = 8'h81;
            w_frame[4]  = rd_ctrl_sta;
            w_frame[5]  = rd_duty_num;
            w_frame[6]  = rd_pulse_dessert[15:8];
            w_frame[7]  = rd_pulse_dessert[7:0];
            w_frame[8]  = rd_pulse_num;
            w_frame[9]  = rd_pat[31:24];
            w_frame[10] = rd_pat[23:16];
            w_frame[11] = rd_pat[15:8];
            w_frame[12] = rd_pat[7:0];
            w_frame[13] = w_status;
            w_frame[14] = w_sum;
            w_last      = 4'd14;
        end else begin
            w_sum      = 8'hEE + r_rd_ch;
            w_frame[2] = 8'hEE;
            w_frame[4] = w_sum;
            w_last     = 4'd4;
        end
    end

    // Registered outputs, frame buffer and byte index
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ch      <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_data    <= 8'h00;
            r_rep_busy   <= 1'b0;
            r_rep_done   <= 1'b0;
            r_req_drop   <= 1'b0;
            r_wait_first <= 1'b0;
            r_idx        <= 4'd0;
            r_last       <= 4'd0;
            for (int i = 0; i < FRAME_MAX; i++) r_buf[i] <= 8'h00;
        end else begin
            r_tx_en      <= w_launch;
            r_rep_done   <= w_finish;
            r_req_drop   <= w_drop;
            r_wait_first <= w_launch;
            if (w_accept) begin
                r_rd_ch    <= rd_req_ch;
                r_rep_busy <= 1'b1;
            end else if (w_finish) begin
                r_rep_busy <= 1'b0;
            end
            if (w_capture) begin
                for (int i = 0; i < FRAME_MAX; i++) r_buf[i] <= w_frame[i];
                r_last <= w_last;
                r_idx  <= 4'd0;
            end else if (w_advance) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_launch) r_tx_data <= r_buf[r_idx];
        end
    end

endmodule

// File: tb/tb_uart_status_reporter.sv
// Bench for uart_status_reporter: models the mapper register file and a
// uart_tx with random busy lengths, and checks frames against a byte-list model.
module tb_uart_status_reporter;

    logic        clk_50M;
    logic        rst_n;
    logic        rd_req;
    logic [7:0]  rd_req_ch;
    logic [7:0]  rd_ch;
    logic [7:0]  rd_ctrl_sta;
    logic [7:0]  rd_duty_num;
    logic [15:0] rd_pulse_dessert;
    logic [7:0]  rd_pulse_num;
    logic [31:0] rd_pat;
    logic        rd_busy;
    logic        rd_valid;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rep_busy;
    logic        rep_done;
    logic        req_drop;

    logic [7:0]  m_ctrl  [256];
    logic [7:0]  m_duty  [256];
    logic [15:0] m_des   [256];
    logic [7:0]  m_pnum  [256];
    logic [31:0] m_pat   [256];
    logic        m_busy  [256];
    logic        m_valid [256];

    int          n_checks;
    int          n_errors;
    int          busy_cnt;
    logic [7:0]  rx [$];

    uart_status_reporter #(._NUM_CHANNELS(4), ._PAT_WIDTH(32)) dut (
        .clk_50M          (clk_50M),
        .rst_n            (rst_n),
        .rd_req           (rd_req),
        .rd_req_ch        (rd_req_ch),
        .rd_ch            (rd_ch),
        .rd_ctrl_sta      (rd_ctrl_sta),
        .rd_duty_num      (rd_duty_num),
        .rd_pulse_dessert (rd_pulse_dessert),
        .rd_pulse_num     (rd_pulse_num),
        .rd_pat           (rd_pat),
        .rd_busy          (rd_busy),
        .rd_valid         (rd_valid),
        .tx_en            (tx_en),
        .tx_data          (tx_data),
        .tx_busy          (tx_busy),
        .rep_busy         (rep_busy),
        .rep_done         (rep_done),
        .req_drop         (req_drop)
    );

    // Mapper lookup: combinational read of the selected channel
    assign rd_ctrl_sta      = m_ctrl[rd_ch];
    assign rd_duty_num      = m_duty[rd_ch];
    assign rd_pulse_dessert = m_des[rd_ch];
    assign rd_pulse_num     = m_pnum[rd_ch];
    assign rd_pat           = m_pat[rd_ch];
    assign rd_busy          = m_busy[rd_ch];
    assign rd_valid         = m_valid[rd_ch];

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ch(input int ch);
        m_ctrl[ch]  = 8'($urandom);
        m_duty[ch]  = 8'($urandom);
        m_des[ch]   = 16'($urandom);
        m_pnum[ch]  = 8'($urandom);
        m_pat[ch]   = $urandom;
        m_busy[ch]  = 1'($urandom);
        m_valid[ch] = 1'($urandom);
    endtask

    // Expected frame: sync bytes, body, then modulo-256 sum of the body
    task automatic build_frame(input int ch, output logic [7:0] q [$]);
        int body [$];
        int sum;
        body.delete();
        if (ch < 4) begin
            body.push_back(8'h81);
            body.push_back(ch);
            body.push_back(int'(m_ctrl[ch]));
            body.push_back(int'(m_duty[ch]));
            body.push_back(int'(m_des[ch]) / 256);
            body.push_back(int'(m_des[ch]) % 256);
            body.push_back(int'(m_pnum[ch]));
            for (int k = 3; k >= 0; k--) body.push_back(int'((m_pat[ch] >> (8 * k)) & 32'hFF));
            body.push_back(2 * int'(m_valid[ch]) + int'(m_busy[ch]));
        end else begin
            body.push_back(8'hEE);
            body.push_back(ch);
        end
        sum = 0;
        q.delete();
        q.push_back(8'h55);
        q.push_back(8'hAA);
        foreach (body[k]) begin
            sum += body[k];
            q.push_back(8'(body[k]));
        end
        q.push_back(8'(sum % 256));
    endtask

    // One request; drop_at/rst_at are byte counts (-1 disables), stall holds tx_busy before the request
    task automatic run_frame(input int ch, input int drop_at, input bit mutate,
                             input int stall, input int rst_at);
        logic [7:0] exp [$];
        int  nen, ndone, ndrop, first_en, last_fall, stall_fall, done_cyc;
        bit  drop_pend, mutated;
        build_frame(ch, exp);
        rx.delete();
        nen = 0; ndone = 0; ndrop = 0; first_en = -1; last_fall = -1;
        stall_fall = -1; done_cyc = -1; drop_pend = 0; mutated = 0;
        @(negedge clk_50M);
        if (stall > 0) begin
            busy_cnt = stall;
            tx_busy  = 1'b1;
        end
        rd_req_ch = 8'(ch);
        rd_req    = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk_50M);
            if (cyc == 1) begin
                rd_req = 1'b0;
                chk("rd_ch_sel", rd_ch, 8'(ch));
                chk("rep_busy_set", rep_busy, 1);
            end
            if (drop_pend) begin
                rd_req    = 1'b0;
                drop_pend = 0;
                chk("req_drop_pulse", req_drop, 1);
            end
            if (req_drop) ndrop++;
            if (tx_en) begin
                chk("tx_en_while_busy", tx_busy, 0);
                if (nen == 0) first_en = cyc;
                rx.push_back(tx_data);
                nen++;
                busy_cnt = $urandom_range(1, 5);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    last_fall = cyc;
                    if (nen == 0) stall_fall = cyc;
                end
            end
            tx_busy = (busy_cnt > 0);
            if (rep_done) begin
                ndone++;
                done_cyc = cyc;
                chk("done_after_fall", cyc - last_fall, 1);
                chk("busy_clr_with_done", rep_busy, 0);
            end
            if (mutate && !mutated && nen >= 1) begin
                m_pat[ch] = 32'h12345678;
                mutated   = 1;
            end
            if (tx_en && nen == drop_at) begin
                rd_req_ch = 8'($urandom_range(0, 7));
                rd_req    = 1'b1;
                drop_pend = 1;
            end
            if (tx_en && nen == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tx_en", tx_en, 0);
                chk("rst_rep_busy", rep_busy, 0);
                chk("rst_rd_ch", rd_ch, 0);
                chk("rst_tx_data", tx_data, 0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk_50M);
                    chk("rst_no_tx_en", tx_en, 0);
                    chk("rst_no_done", rep_done, 0);
                end
                rst_n    = 1'b1;
                busy_cnt = 0;
                tx_busy  = 1'b0;
                return;
            end
            if (ndone > 0 && cyc >= done_cyc + 3) break;
        end
        chk("rep_done_count", ndone, 1);
        chk("req_drop_count", ndrop, (drop_at >= 0) ? 1 : 0);
        chk("rep_busy_idle", rep_busy, 0);
        chk("nbytes", rx.size(), exp.size());
        for (int k = 0; k < exp.size() && k < rx.size(); k++)
            chk($sformatf("byte%0d", k), rx[k], exp[k]);
        if (stall > 0) chk("stall_first_en", first_en - stall_fall, 1);
        else           chk("first_en_latency", first_en, 4);
    endtask

    initial begin
        logic [7:0] golden [15];
        n_checks  = 0;
        n_errors  = 0;
        busy_cnt  = 0;
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        rd_req_ch = 8'h00;
        tx_busy   = 1'b0;
        for (int c = 0; c < 256; c++) begin
            m_ctrl[c] = 0; m_duty[c] = 0; m_des[c] = 0; m_pnum[c] = 0;
            m_pat[c] = 0; m_busy[c] = 0; m_valid[c] = 0;
        end
        for (int c = 0; c < 4; c++) rand_ch(c);

        repeat (3) @(negedge clk_50M);
        chk("reset_rd_ch", rd_ch, 0);
        chk("reset_tx_en", tx_en, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_rep_busy", rep_busy, 0);
        chk("reset_rep_done", rep_done, 0);
        chk("reset_req_drop", req_drop, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // Known-answer frame
        m_ctrl[1] = 8'h01; m_duty[1] = 8'h10; m_des[1] = 16'h0100; m_pnum[1] = 8'h05;
        m_pat[1] = 32'hAAAA5555; m_busy[1] = 1'b1; m_valid[1] = 1'b0;
        run_frame(1, -1, 0, 0, -1);
        golden = '{8'h55, 8'hAA, 8'h81, 8'h01, 8'h01, 8'h10, 8'h01, 8'h00,
                   8'h05, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h01, 8'h98};
        chk("golden_len", rx.size(), 15);
        for (int k = 0; k < 15 && k < rx.size(); k++)
            chk($sformatf("golden%0d", k), rx[k], golden[k]);

        // Invalid channel
        run_frame(7, -1, 0, 0, -1);
        chk("err_frame_sum", (rx.size() == 5) ? rx[4] : 8'h00, 8'hF5);

        // Busy collision during byte 5
        rand_ch(1);
        run_frame(1, 5, 0, 0, -1);

        // Snapshot freeze
        rand_ch(2);
        m_pat[2] = 32'hAAAA5555;
        run_frame(2, -1, 1, 0, -1);
        chk("freeze_pat", (rx.size() == 15) ? {rx[9], rx[10], rx[11], rx[12]} : 32'h0,
            32'hAAAA5555);

        // Handshake stall before the first byte
        rand_ch(0);
        run_frame(0, -1, 0, 100, -1);

        // Reset mid-frame, then a full frame
        rand_ch(3);
        run_frame(3, -1, 0, 0, 8);
        repeat (2) @(negedge clk_50M);
        run_frame(3, -1, 0, 0, -1);

        // Random frames
        for (int t = 0; t < 8; t++) begin
            int ch;
            ch = $urandom_range(0, 7);
            if (ch < 4) rand_ch(ch);
            run_frame(ch, -1, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
